mem_arbiter: RTL

Two-port arbiter and sequencer for the 64 x 8 byte-wide data memory. It lets the instruction-fetch unit (requester 0) and the load/store unit (requester 1) share the single memory port. Each access is a 16-bit little-endian word split into two byte cycles. The block sits between the CPU control path and the memory and is the only driver of the memory's `we`, `addr` and `data` inputs.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter_rr_arb2.sv | 44 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
//   state_t          - sequencer states (IDLE, LO, HI, RESP)
//   REQ_FETCH/REQ_LSU - requester index constants
//   DEF_ADDR_W/DEF_DATA_W - default byte-address and byte widths
package mem_arbiter_pkg;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LSU   = 1;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake plus memory port bundle.
//   req_valid/req_we/req_addr/req_wdata - per-requester request (index 0 fetch, 1 LSU)
//   req_ready                            - combinational grant
//   rsp_done/rsp_rdata                   - completion pulse and held read word
//   mem_we/mem_addr/mem_data/mem_out     - byte-wide memory port
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]                   req_valid;
    logic [1:0]                   req_we;
    logic [1:0][ADDR_W-1:0]       req_addr;
    logic [1:0][2*DATA_W-1:0]     req_wdata;
    logic [1:0]                   req_ready;
    logic [1:0]                   rsp_done;
    logic [1:0][2*DATA_W-1:0]     rsp_rdata;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_data;
    logic [DATA_W-1:0]            mem_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_out,
        output req_ready, rsp_done, rsp_rdata, mem_we, mem_addr, mem_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_out,
        input  req_ready, rsp_done, rsp_rdata, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way grant picker.
//   en  - arbiter may grant this cycle
//   req - request vector
//   gnt - one-hot grant (zero when en is low or no request)
// Default: round-robin with a one-bit preferred-requester pointer that moves
// to the loser after every grant. With MEM_ARBITER_FIXED_PRIO_EN defined,
// requester 0 always wins and the pointer (and its clock/reset) disappears.
module rr_arb2 (
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end
`else
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
            else              gnt = req;
            // Point at whichever requester did not get this grant.
            if (|req) ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide memory between fetch (0) and LSU (1).
// Each 16-bit little-endian word access takes IDLE(accept) -> LO -> HI -> RESP.
//   clk  - rising-edge clock shared with the memory
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: request/response handshake and memory port
// Optional: MEM_ARBITER_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_t                    state_q, state_d;
    logic                      we_q, we_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [2*DATA_W-1:0]       wdata_q, wdata_d;
    logic                      win_q, win_d;
    logic [DATA_W-1:0]         rlo_q, rlo_d;
    logic [1:0][2*DATA_W-1:0]  rdata_q, rdata_d;

    logic [1:0]                gnt;
    logic                      arb_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic [1:0]                rsp_done;

    // Grants only in IDLE; rst gating keeps req_ready low while reset is held.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arb2 u_arb (
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        .clk (clk),
        .rst (rst),
`endif
        .en  (arb_en),
        .req (bus.req_valid),
        .gnt (gnt)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        win_d    = win_q;
        rlo_d    = rlo_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        rsp_done = 2'b00;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    win_d   = gnt[REQ_LSU];
                    we_d    = bus.req_we[win_d];
                    addr_d  = bus.req_addr[win_d];
                    wdata_d = bus.req_wdata[win_d];
                    state_d = LO;
                end
            end
            LO: begin
                mem_addr = addr_q;
                if (we_q) begin
                    mem_we   = 1'b1;
                    mem_data = wdata_q[DATA_W-1:0];
                end else begin
                    rlo_d = bus.mem_out;
                end
                state_d = HI;
            end
            HI: begin
                // High byte address wraps naturally at ADDR_W bits.
                mem_addr = addr_q + ADDR_W'(1);
                if (we_q) begin
                    mem_we   = 1'b1;
                    mem_data = wdata_q[2*DATA_W-1:DATA_W];
                end else begin
                    // Publish the full word so it is valid during RESP.
                    rdata_d[win_q] = {bus.mem_out, rlo_q};
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_done[win_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            win_q   <= 1'b0;
            rlo_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            win_q   <= win_d;
            rlo_q   <= rlo_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_done  = rsp_done;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_data  = mem_data;
endmodule
